// File: rtl/zoom_out_avg_engine_if.sv
// Port bundle between the zoom-out averaging engine and the controller / RAM muxes.
// The master side is the engine; the slave side is the controller plus the RAMs.
interface zoom_out_avg_engine_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              busy;
    logic              done;

    modport master (
        input  start, rd_data,
        output rd_addr, wr_addr, wr_data, wr_en, busy, done
    );

    modport slave (
        output start, rd_data,
        input  rd_addr, wr_addr, wr_data, wr_en, busy, done
    );
endinterface

// File: rtl/zoom_out_avg_engine.sv
// 2x2 block-averaging engine writing a centred half-size frame; 5 cycles per output pixel.
// Define CLEAR_BORDER_EN to blank the whole destination (CLEAR state) before averaging.
module zoom_out_avg_engine #(
    parameter int SRC_W  = 320,
    parameter int SRC_H  = 240,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    zoom_out_avg_engine_if.master bus
);
    localparam int OW = SRC_W / 2;
    localparam int OH = SRC_H / 2;
    localparam int XW = $clog2(OW + 1);
    localparam int YW = $clog2(OH + 1);
    localparam int AW = DATA_W + 2;

    localparam logic [ADDR_W-1:0] ONE          = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO          = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ROW          = ADDR_W'(SRC_W);
    localparam logic [ADDR_W-1:0] SRC_ROW_STEP = ADDR_W'(SRC_W + 2);
    localparam logic [ADDR_W-1:0] DST_ROW_STEP = ADDR_W'(SRC_W - OW + 1);
    localparam logic [ADDR_W-1:0] DST_BASE     = ADDR_W'((SRC_H / 4) * SRC_W + SRC_W / 4);
`ifdef CLEAR_BORDER_EN
    localparam logic [ADDR_W-1:0] CLR_LAST     = ADDR_W'(SRC_W * SRC_H - 1);
`endif

    typedef enum logic [2:0] {
        IDLE, RD0, RD1, RD2, RD3, WR, FIN
`ifdef CLEAR_BORDER_EN
        , CLEAR
`endif
    } state_t;

    state_t            state_q;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [AW-1:0]     acc_q, sum;
    logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
    logic              wr_en_q, busy_q, done_q;
    logic              last_x, last_y;

    // src_q tracks the top-left source pixel, dst_q the destination of the current block
    always_comb begin
        last_x = (x_q == XW'(OW - 1));
        last_y = (y_q == YW'(OH - 1));
        x_d    = last_x ? '0 : x_q + XW'(1);
        y_d    = last_x ? y_q + YW'(1) : y_q;
        src_d  = src_q + (last_x ? SRC_ROW_STEP : TWO);
        dst_d  = dst_q + (last_x ? DST_ROW_STEP : ONE);
        sum    = acc_q + AW'(bus.rd_data);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            acc_q     <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        busy_q    <= 1'b1;
                        x_q       <= '0;
                        y_q       <= '0;
                        src_q     <= '0;
                        dst_q     <= DST_BASE;
                        rd_addr_q <= '0;
`ifdef CLEAR_BORDER_EN
                        state_q   <= CLEAR;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= '0;
`else
                        state_q   <= RD0;
`endif
                    end
                end
`ifdef CLEAR_BORDER_EN
                CLEAR: begin
                    if (wr_addr_q == CLR_LAST) begin
                        wr_en_q <= 1'b0;
                        state_q <= RD0;
                    end else begin
                        wr_addr_q <= wr_addr_q + ONE;
                    end
                end
`endif
                // rd_addr is registered one state ahead so RAM data lines up with RD1..WR
                RD0: begin
                    acc_q     <= '0;
                    rd_addr_q <= src_q + ONE;
                    state_q   <= RD1;
                end
                RD1: begin
                    acc_q     <= sum;
                    rd_addr_q <= src_q + ROW;
                    state_q   <= RD2;
                end
                RD2: begin
                    acc_q     <= sum;
                    rd_addr_q <= src_q + ROW + ONE;
                    state_q   <= RD3;
                end
                RD3: begin
                    acc_q     <= sum;
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= dst_q;
                    state_q   <= WR;
                end
                WR: begin
                    wr_en_q <= 1'b0;
                    x_q     <= x_d;
                    y_q     <= y_d;
                    src_q   <= src_d;
                    dst_q   <= dst_d;
                    if (last_x && last_y) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        rd_addr_q <= src_d;
                        state_q   <= RD0;
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rd_addr = rd_addr_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.wr_data = (state_q == WR) ? DATA_W'(sum >> 2) : '0;
endmodule

// File: tb/tb_zoom_out_avg_engine.sv
// Scoreboard bench for zoom_out_avg_engine on a reduced 16x12 frame.
// Stimulus queues expected writes/done; a negedge monitor pops and compares them.
module tb_zoom_out_avg_engine;
    localparam int W    = 16;
    localparam int H    = 12;
    localparam int AW   = 17;
    localparam int DW   = 8;
    localparam int OW   = W / 2;
    localparam int OH   = H / 2;
    localparam int P    = OW * OH;
    localparam int NPIX = W * H;
    localparam int DST_FIRST = 52;   // (0+3)*16 + (0+4)
    localparam int DST_LAST  = 139;  // (5+3)*16 + (7+4)
`ifdef CLEAR_BORDER_EN
    localparam int CLR = NPIX;
    localparam int BORDER = 0;
`else
    localparam int CLR = 0;
    localparam int BORDER = 8'hAA;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dst_fill = 1'b0;
    always #5 clk = ~clk;

    zoom_out_avg_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    zoom_out_avg_engine #(.SRC_W(W), .SRC_H(H), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    logic [7:0] src_mem [NPIX];
    logic [7:0] dst_mem [NPIX];
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        bus.rd_data <= (int'(bus.rd_addr) < NPIX) ? src_mem[bus.rd_addr] : 8'h00;
        if (dst_fill) begin
            for (int i = 0; i < NPIX; i++) dst_mem[i] <= 8'hAA;
        end else if (bus.wr_en === 1'b1 && int'(bus.wr_addr) < NPIX) begin
            dst_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_done[$];
    wr_t mon_e;
    int  mon_d;
    int  n_chk = 0;
    int  n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %0d expected nothing (cycle %0d)", name, act, cyc);
    endtask

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            if (exp_wr.size() == 0) begin
                flag("unexpected_write", bus.wr_addr);
            end else begin
                mon_e = exp_wr.pop_front();
                chk("wr_addr", bus.wr_addr, mon_e.addr);
                chk("wr_data", bus.wr_data, mon_e.data);
                chk("wr_cycle", cyc + 1, mon_e.cyc);
                chk("busy_during_wr", bus.busy, 1);
            end
        end
        if (bus.done === 1'b1) begin
            if (exp_done.size() == 0) begin
                flag("unexpected_done", cyc + 1);
            end else begin
                mon_d = exp_done.pop_front();
                chk("done_cycle", cyc + 1, mon_d);
                chk("busy_at_done", bus.busy, 0);
            end
        end
    end

    function automatic int avg_exp(input int x, input int y);
        int s;
        s = int'(src_mem[2*y*W + 2*x]) + int'(src_mem[2*y*W + 2*x + 1])
          + int'(src_mem[(2*y+1)*W + 2*x]) + int'(src_mem[(2*y+1)*W + 2*x + 1]);
        return s / 4;
    endfunction

    task automatic fill_src(input int v);
        for (int i = 0; i < NPIX; i++) src_mem[i] = 8'(v);
    endtask

    task automatic clear_dst();
        @(negedge clk);
        dst_fill = 1'b1;
        @(negedge clk);
        dst_fill = 1'b0;
    endtask

    // rst_at > 0 aborts the pass with a one-cycle reset in cycle n+rst_at
    task automatic run_pass(input int rst_at, input bit extra_start);
        int  n;
        wr_t e;
        int  p5;
        p5 = 5 * P;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = cyc;
        chk("busy_after_start", bus.busy, 1);
        for (int i = 0; i < CLR; i++) begin
            e.addr = i; e.data = 0; e.cyc = n + 1 + i;
            exp_wr.push_back(e);
        end
        for (int y = 0; y < OH; y++) begin
            for (int x = 0; x < OW; x++) begin
                e.addr = (y + H/4) * W + x + W/4;
                e.data = avg_exp(x, y);
                e.cyc  = n + CLR + 5 + 5 * (y * OW + x);
                exp_wr.push_back(e);
            end
        end
        exp_done.push_back(n + CLR + p5 + 1);
        for (int i = 0; i < CLR + p5 + 12; i++) begin
            bus.start = (extra_start && (i == 9 || i == CLR + p5)) ? 1'b1 : 1'b0;
            if (rst_at == 0) begin
                if (i == CLR + p5 - 1) chk("busy_last_write", bus.busy, 1);
                if (i == CLR + p5)     chk("busy_in_fin", bus.busy, 0);
                if (i == CLR + p5 + 1) chk("busy_after_fin", bus.busy, 0);
            end else begin
                if (i == rst_at - 1) rst = 1'b1;
                if (i == rst_at) begin
                    rst = 1'b0;
                    exp_wr.delete();
                    exp_done.delete();
                    chk("rst_mid_wr_en", bus.wr_en, 0);
                    chk("rst_mid_busy", bus.busy, 0);
                    chk("rst_mid_rd_addr", bus.rd_addr, 0);
                    chk("rst_mid_wr_addr", bus.wr_addr, 0);
                    chk("rst_mid_done", bus.done, 0);
                end
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("writes_outstanding", exp_wr.size(), 0);
        chk("done_outstanding", exp_done.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        rst = 1'b1;
        fill_src(0);
        repeat (3) @(negedge clk);
        chk("reset_rd_addr", bus.rd_addr, 0);
        chk("reset_wr_addr", bus.wr_addr, 0);
        chk("reset_wr_data", bus.wr_data, 0);
        chk("reset_wr_en", bus.wr_en, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        rst = 1'b0;

        // uniform 100
        fill_src(100);
        clear_dst();
        run_pass(0, 1'b0);
        chk("uniform_first_pixel", dst_mem[DST_FIRST], 100);
        chk("border_addr0", dst_mem[0], BORDER);
        chk("border_last_addr", dst_mem[NPIX-1], BORDER);
        chk("border_before_window", dst_mem[DST_FIRST-1], BORDER);

        // single 1,2,3,4 block -> floor(10/4) = 2
        fill_src(0);
        src_mem[0] = 8'd1; src_mem[1] = 8'd2; src_mem[W] = 8'd3; src_mem[W+1] = 8'd4;
        run_pass(0, 1'b0);
        chk("block_avg_first", dst_mem[DST_FIRST], 2);
        chk("block_avg_next", dst_mem[DST_FIRST+1], 0);

        // saturated source, no accumulator wrap
        fill_src(255);
        run_pass(0, 1'b0);
        chk("max_last_pixel", dst_mem[DST_LAST], 255);

        // non-uniform pattern exercising truncation
        for (int i = 0; i < NPIX; i++) src_mem[i] = 8'((i * 37 + 11) & 255);
        run_pass(0, 1'b0);

        // reset mid-pass, then a fresh complete pass
        fill_src(100);
        run_pass(52, 1'b0);
        run_pass(0, 1'b0);

        // start pulses while busy and in FIN are ignored
        fill_src(60);
        run_pass(0, 1'b1);

        // all-200 source with fresh destination
        fill_src(200);
        clear_dst();
        run_pass(0, 1'b0);
        chk("fill_border_addr0", dst_mem[0], BORDER);
        chk("fill_border_edge", dst_mem[DST_FIRST-1], BORDER);
        chk("fill_window_first", dst_mem[DST_FIRST], 200);
        chk("fill_window_last", dst_mem[DST_LAST], 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
